// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter: FSM states,
// requester index type and the round-robin pointer advance.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int N_REQ_MAX      = 8;
  localparam int IDX_W          = $clog2(N_REQ_MAX);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Pointer moves one past the winner, wrapping at the last requester.
  function automatic req_idx_t rr_next(input req_idx_t idx, input int n_req);
    if (int'(idx) >= n_req - 1) begin
      return '0;
    end
    return idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr_i, searching upward and wrapping from N_REQ-1 back to 0.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  req_idx_t         ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output req_idx_t         gnt_idx_o,
  output logic             any_req_o
);

  logic [N_REQ-1:0] req_rot;
  logic [N_REQ-1:0] pick_rot;
  logic [N_REQ:0]   seen;
  req_idx_t         idx_acc [N_REQ+1];

  // Rotate right so the pointer position sits at bit 0; the lowest set bit wins.
  assign req_rot = (req_i >> ptr_i) | (req_i << (N_REQ - int'(ptr_i)));
  assign seen[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pick
      assign pick_rot[gi] = req_rot[gi] & ~seen[gi];
      assign seen[gi+1]   = seen[gi] | req_rot[gi];
    end
  endgenerate

  assign any_req_o = seen[N_REQ];
  assign gnt_o     = (pick_rot << ptr_i) | (pick_rot >> (N_REQ - int'(ptr_i)));

  assign idx_acc[0] = '0;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_idx
      assign idx_acc[gi+1] = idx_acc[gi] | (gnt_o[gi] ? req_idx_t'(gi) : '0);
    end
  endgenerate

  assign gnt_idx_o = idx_acc[N_REQ];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory port between N_REQ requesters: accepts one
// read at a time round-robin, waits out MEM_LATENCY, then strobes the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            REQ_VALID,
  input  logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  output logic [N_REQ-1:0]            REQ_READY,
  output logic [N_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]       RSP_DATA,
  output logic [ADDR_WIDTH-1:0]       MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]       MEM_DATA,
  output logic                        BUSY
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  req_idx_t              owner_q;
  req_idx_t              ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic                  busy_q;

  logic [N_REQ-1:0]      gnt;
  req_idx_t              gnt_idx;
  logic                  any_req;
  logic                  accept_ok;
  logic [N_REQ-1:0]      owner_hot;
  logic [ADDR_WIDTH-1:0] addr_acc [N_REQ+1];

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req_i    (REQ_VALID),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .any_req_o(any_req)
  );

  // Accepts happen only from IDLE or RESP, never while reset is asserted.
  assign accept_ok = !RST && any_req && (state_q == IDLE || state_q == RESP);
  assign REQ_READY = accept_ok ? gnt : '0;

  assign addr_acc[0] = '0;
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_acc[gi+1] = addr_acc[gi] |
                              (gnt[gi] ? REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0);
      assign owner_hot[gi]  = (owner_q == req_idx_t'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE, RESP: begin
          if (accept_ok) begin
            mem_addr_q <= addr_acc[N_REQ];
            owner_q    <= gnt_idx;
            ptr_q      <= rr_next(gnt_idx, N_REQ);
            cnt_q      <= CNT_W'(MEM_LATENCY);
            state_q    <= WAIT;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Last WAIT cycle: memory data is valid in the next (RESP) cycle.
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= owner_hot;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDR  = mem_addr_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = MEM_DATA;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-1 instance with a registered memory
// and a latency-3 instance with a three-stage delayed memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];

  // Latency-1 instance
  logic        rst;
  logic [1:0]  req_valid;
  logic [23:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [11:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;

  // Latency-3 instance
  logic        rst3;
  logic [1:0]  req_valid3;
  logic [23:0] req_addr3;
  logic [1:0]  req_ready3;
  logic [1:0]  rsp_valid3;
  logic [15:0] rsp_data3;
  logic [11:0] mem_addr3;
  logic [15:0] mem_data3;
  logic        busy3;
  logic [15:0] m3_s0, m3_s1, m3_s2;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_arbiter #(.N_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(16), .MEM_LATENCY(1)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_ADDR(req_addr),
    .REQ_READY(req_ready), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .BUSY(busy)
  );

  mem_arbiter #(.N_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(16), .MEM_LATENCY(3)) dut3 (
    .CLK(clk), .RST(rst3), .REQ_VALID(req_valid3), .REQ_ADDR(req_addr3),
    .REQ_READY(req_ready3), .RSP_VALID(rsp_valid3), .RSP_DATA(rsp_data3),
    .MEM_ADDR(mem_addr3), .MEM_DATA(mem_data3), .BUSY(busy3)
  );

  logic [15:0] mem_q;
  always @(posedge clk) begin
    mem_q <= mem[mem_addr];
    m3_s0 <= mem[mem_addr3];
    m3_s1 <= m3_s0;
    m3_s2 <= m3_s1;
  end
  assign mem_data  = mem_q;
  assign mem_data3 = m3_s2;

  // Protocol watch: one-hot strobes, and addresses held while a request waits.
  logic [1:0]  pend_q;
  logic [23:0] addr_prev_q;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (pend_q[i] && req_valid[i])
          assert (req_addr[i*12 +: 12] == addr_prev_q[i*12 +: 12])
            else $error("requester %0d changed address while pending", i);
      end
      assert ($onehot0(req_ready)) else $error("req_ready not one-hot0: %b", req_ready);
      assert ($onehot0(rsp_valid)) else $error("rsp_valid not one-hot0: %b", rsp_valid);
    end
    pend_q      <= rst ? 2'b00 : (req_valid & ~req_ready);
    addr_prev_q <= req_addr;
  end

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_addr = {12'd0, 12'd1};
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 2'b00); end
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL reset_rsp got=%b exp=%b", rsp_valid, 2'b00); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vec_cnt++; if (mem_addr !== 12'd0) begin err_cnt++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
    @(negedge clk); rst = 1'b0; req_valid = 2'b00; #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    $display("reset: outputs idle, MEM_ADDR=%h", mem_addr);
  endtask

  task automatic test_single_read();
    @(negedge clk); req_valid = 2'b01; req_addr = {12'd0, 12'd1}; #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_T got=%b exp=0", busy); end
    @(negedge clk); req_valid = 2'b00; #1;
    vec_cnt++; if (mem_addr !== 12'd1) begin err_cnt++; $display("FAIL single_mem_addr got=%h exp=001", mem_addr); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_T1 got=%b exp=1", busy); end
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL single_rsp_T1 got=%b exp=00", rsp_valid); end
    @(negedge clk); #1;
    vec_cnt++; if (rsp_valid !== 2'b01) begin err_cnt++; $display("FAIL single_rsp_T2 got=%b exp=01", rsp_valid); end
    vec_cnt++; if (rsp_data !== 16'hBEEF) begin err_cnt++; $display("FAIL single_data got=%h exp=beef", rsp_data); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_T2 got=%b exp=1", busy); end
    @(negedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_T3 got=%b exp=0", busy); end
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL single_rsp_T3 got=%b exp=00", rsp_valid); end
    vec_cnt++; if (mem_addr !== 12'd1) begin err_cnt++; $display("FAIL single_addr_hold got=%h exp=001", mem_addr); end
    $display("single_read: req0 addr=001 data=%h", 16'hBEEF);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ready, exp_rsp;
    logic [15:0] exp_data;
    @(negedge clk); rst = 1'b1; req_valid = 2'b11; req_addr = {12'd0, 12'd1};
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 8) req_valid = 2'b00;
      #1;
      if (k % 2 == 0) begin
        exp_ready = (k == 8) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
        exp_rsp   = (k == 0) ? 2'b00 : ((((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        exp_ready = 2'b00;
        exp_rsp   = 2'b00;
      end
      exp_data = (exp_rsp == 2'b01) ? 16'hBEEF : 16'h0000;
      vec_cnt++; if (req_ready !== exp_ready) begin err_cnt++; $display("FAIL contend_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
      vec_cnt++; if (rsp_valid !== exp_rsp) begin err_cnt++; $display("FAIL contend_rsp k=%0d got=%b exp=%b", k, rsp_valid, exp_rsp); end
      vec_cnt++; if (busy !== (k != 0)) begin err_cnt++; $display("FAIL contend_busy k=%0d got=%b exp=%b", k, busy, (k != 0)); end
      if (exp_rsp != 2'b00) begin
        vec_cnt++; if (rsp_data !== exp_data) begin err_cnt++; $display("FAIL contend_data k=%0d got=%h exp=%h", k, rsp_data, exp_data); end
        $display("contention: rsp to %b data=%h", exp_rsp, exp_data);
      end
      if (k % 2 == 1) begin
        vec_cnt++;
        if (mem_addr !== ((((k - 1) / 2) % 2 == 0) ? 12'd1 : 12'd0)) begin
          err_cnt++; $display("FAIL contend_mem_addr k=%0d got=%h", k, mem_addr);
        end
      end
    end
    @(negedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL contend_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fairness();
    @(negedge clk); req_valid = 2'b10; req_addr = {12'd0, 12'd1}; #1;
    vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL fair_ready1 got=%b exp=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    @(negedge clk); #1;
    vec_cnt++; if (rsp_valid !== 2'b10) begin err_cnt++; $display("FAIL fair_rsp1 got=%b exp=10", rsp_valid); end
    vec_cnt++; if (rsp_data !== 16'h0000) begin err_cnt++; $display("FAIL fair_data1 got=%h exp=0000", rsp_data); end
    repeat (3) @(negedge clk);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fair_idle got=%b exp=0", busy); end
    @(negedge clk); req_valid = 2'b11; #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL fair_ready0 got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    @(negedge clk); #1;
    vec_cnt++; if (rsp_valid !== 2'b01) begin err_cnt++; $display("FAIL fair_rsp0 got=%b exp=01", rsp_valid); end
    vec_cnt++; if (rsp_data !== 16'hBEEF) begin err_cnt++; $display("FAIL fair_data0 got=%h exp=beef", rsp_data); end
    @(negedge clk); #1;
    $display("fairness: req1 then req0 after idle");
  endtask

  task automatic test_withdrawn();
    @(negedge clk); req_valid = 2'b10; req_addr = {12'd2, 12'd1}; #1;
    vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL wd_ready1 got=%b exp=10", req_ready); end
    @(negedge clk); req_valid = 2'b01; req_addr = {12'd2, 12'd3}; #1;
    vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL wd_ready_wait got=%b exp=00", req_ready); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wd_busy got=%b exp=1", busy); end
    @(negedge clk); req_valid = 2'b00; #1;
    vec_cnt++; if (rsp_valid !== 2'b10) begin err_cnt++; $display("FAIL wd_rsp got=%b exp=10", rsp_valid); end
    vec_cnt++; if (rsp_data !== 16'h1234) begin err_cnt++; $display("FAIL wd_data got=%h exp=1234", rsp_data); end
    vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL wd_ready_resp got=%b exp=00", req_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wd_idle k=%0d got=%b exp=0", k, busy); end
      vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL wd_no_rsp k=%0d got=%b exp=00", k, rsp_valid); end
      vec_cnt++; if (mem_addr !== 12'd2) begin err_cnt++; $display("FAIL wd_mem_addr k=%0d got=%h exp=002", k, mem_addr); end
    end
    $display("withdrawn: req1 addr=002 served, req0 withdrawn");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); req_valid = 2'b01; req_addr = {12'd2, 12'd1}; #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL rmid_ready got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; rst = 1'b1; #1;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rmid_busy_wait got=%b exp=1", busy); end
    @(negedge clk); rst = 1'b0; #1;
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL rmid_rsp got=%b exp=00", rsp_valid); end
    vec_cnt++; if (mem_addr !== 12'd0) begin err_cnt++; $display("FAIL rmid_mem_addr got=%h exp=000", mem_addr); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    @(negedge clk); #1;
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL rmid_rsp2 got=%b exp=00", rsp_valid); end
    @(negedge clk); req_valid = 2'b11; #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL rmid_first_grant got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    @(negedge clk); #1;
    vec_cnt++; if (rsp_valid !== 2'b01) begin err_cnt++; $display("FAIL rmid_post_rsp got=%b exp=01", rsp_valid); end
    vec_cnt++; if (rsp_data !== 16'hBEEF) begin err_cnt++; $display("FAIL rmid_post_data got=%h exp=beef", rsp_data); end
    @(negedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_end_idle got=%b exp=0", busy); end
    $display("reset_mid: in-flight req0 dropped, next grant req0");
  endtask

  task automatic test_latency3();
    logic [1:0]  exp_ready, exp_rsp;
    logic [15:0] exp_data;
    @(negedge clk); rst3 = 1'b1; req_valid3 = 2'b11; req_addr3 = {12'd0, 12'd1};
    @(negedge clk); rst3 = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 12) req_valid3 = 2'b00;
      #1;
      if (k % 4 == 0) begin
        exp_ready = (k == 12) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
        exp_rsp   = (k == 0) ? 2'b00 : ((((k / 4) - 1) % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        exp_ready = 2'b00;
        exp_rsp   = 2'b00;
      end
      exp_data = (exp_rsp == 2'b01) ? 16'hBEEF : 16'h0000;
      vec_cnt++; if (req_ready3 !== exp_ready) begin err_cnt++; $display("FAIL lat3_ready k=%0d got=%b exp=%b", k, req_ready3, exp_ready); end
      vec_cnt++; if (rsp_valid3 !== exp_rsp) begin err_cnt++; $display("FAIL lat3_rsp k=%0d got=%b exp=%b", k, rsp_valid3, exp_rsp); end
      vec_cnt++; if (busy3 !== (k != 0)) begin err_cnt++; $display("FAIL lat3_busy k=%0d got=%b exp=%b", k, busy3, (k != 0)); end
      if (exp_rsp != 2'b00) begin
        vec_cnt++; if (rsp_data3 !== exp_data) begin err_cnt++; $display("FAIL lat3_data k=%0d got=%h exp=%h", k, rsp_data3, exp_data); end
        $display("latency3: rsp to %b data=%h", exp_rsp, exp_data);
      end
    end
    @(negedge clk); #1;
    vec_cnt++; if (busy3 !== 1'b0) begin err_cnt++; $display("FAIL lat3_idle got=%b exp=0", busy3); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'hDEAD;
    mem[0] = 16'h0000;
    mem[1] = 16'hBEEF;
    mem[2] = 16'h1234;
    rst = 1'b1; req_valid = 2'b00; req_addr = '0;
    rst3 = 1'b1; req_valid3 = 2'b00; req_addr3 = '0;

    test_reset();
    test_single_read();
    test_back_to_back();
    test_fairness();
    test_withdrawn();
    test_reset_mid();
    test_latency3();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not complete got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
